// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: 32x8 program/data memory target for the accumulator CPU.
// Read/write strobes are acknowledged after RD_WAIT/WR_WAIT wait states with a
// one-cycle registered mem_ack. A valid/ready loader port preloads words while
// the CPU is idle. Optional feature macro: CPU_MEM_PARITY_EN (per-word even
// parity with a sticky par_err flag).
`timescale 1ns/1ps
module cpu_mem_responder #(
    parameter int WORD_W  = 8,
    parameter int ADDR_W  = 5,
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [WORD_W-1:0] mem_wdata,
    output logic [WORD_W-1:0] mem_rdata,
    output logic              mem_ack,
    output logic              mem_err,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [WORD_W-1:0] ld_data,
    output logic              par_err
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        RD_W,
        WR_W,
        RESP,
        ERR
    } state_t;

    state_t            state;
    logic [2:0]        wait_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [WORD_W-1:0] mem [DEPTH];
`ifdef CPU_MEM_PARITY_EN
    logic              mem_par [DEPTH];
`endif

    logic              rd_commit;
    logic              wr_commit;
    logic              ld_write;
    logic [ADDR_W-1:0] acc_addr;
    logic [WORD_W-1:0] acc_wdata;

    // Loader is only served while idle and the CPU is not requesting.
    assign ld_ready = rst_n && (state == IDLE) && !mem_rd && !mem_wr;
    assign ld_write = ld_valid && ld_ready;

    // Decide whether the coming edge is the edge entering RESP; with zero wait
    // states that edge is the acceptance edge, so the live inputs are used.
    always_comb begin
        rd_commit = 1'b0;
        wr_commit = 1'b0;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    acc_addr  = mem_addr;
                    acc_wdata = mem_wdata;
                    if (mem_rd && !mem_wr && (RD_WAIT == 0)) rd_commit = 1'b1;
                    if (mem_wr && !mem_rd && (WR_WAIT == 0)) wr_commit = 1'b1;
                end
                RD_W:    if (wait_cnt == 3'd1) rd_commit = 1'b1;
                WR_W:    if (wait_cnt == 3'd1) wr_commit = 1'b1;
                default: ;
            endcase
        end
    end

    // Memory array (and parity bits): not reset; CPU write or loader write.
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            mem[acc_addr] <= acc_wdata;
`ifdef CPU_MEM_PARITY_EN
            mem_par[acc_addr] <= ^acc_wdata;
`endif
        end else if (ld_write) begin
            mem[ld_addr] <= ld_data;
`ifdef CPU_MEM_PARITY_EN
            mem_par[ld_addr] <= ^ld_data;
`endif
        end
    end

    // Access FSM with registered ack/err/rdata (and sticky parity flag).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mem_rdata <= '0;
            mem_ack   <= 1'b0;
            mem_err   <= 1'b0;
`ifdef CPU_MEM_PARITY_EN
            par_err   <= 1'b0;
`endif
        end else begin
            mem_ack <= 1'b0;
            mem_err <= 1'b0;
            if (rd_commit) begin
                mem_rdata <= mem[acc_addr];
`ifdef CPU_MEM_PARITY_EN
                if ((^mem[acc_addr]) != mem_par[acc_addr]) par_err <= 1'b1;
`endif
            end
            case (state)
                IDLE: begin
                    if (mem_rd || mem_wr) begin
                        addr_q  <= mem_addr;
                        wdata_q <= mem_wdata;
                        if (mem_rd && mem_wr) begin
                            state    <= ERR;
                            wait_cnt <= '0;
                            mem_ack  <= 1'b1;
                            mem_err  <= 1'b1;
                        end else if (mem_rd) begin
                            wait_cnt <= 3'(RD_WAIT);
                            if (RD_WAIT == 0) begin
                                state   <= RESP;
                                mem_ack <= 1'b1;
                            end else begin
                                state <= RD_W;
                            end
                        end else begin
                            wait_cnt <= 3'(WR_WAIT);
                            if (WR_WAIT == 0) begin
                                state   <= RESP;
                                mem_ack <= 1'b1;
                            end else begin
                                state <= WR_W;
                            end
                        end
                    end
                end
                RD_W, WR_W: begin
                    if (wait_cnt == 3'd1) begin
                        state    <= RESP;
                        wait_cnt <= '0;
                        mem_ack  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                RESP:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifndef CPU_MEM_PARITY_EN
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Testbench for cpu_mem_responder: two instances (RD_WAIT=1/WR_WAIT=2 and
// RD_WAIT=0/WR_WAIT=0) exercised one at a time. Expected acks are queued when
// a request is issued and checked by an independent monitor.
`timescale 1ns/1ps
module tb_cpu_mem_responder;
    localparam int AW  = 5;
    localparam int DW  = 8;
    localparam int NCH = 2;
    localparam int RDW0 = 1, WRW0 = 2, RDW1 = 0, WRW1 = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic          mem_rd   [NCH];
    logic          mem_wr   [NCH];
    logic          mem_ack  [NCH];
    logic          mem_err  [NCH];
    logic          ld_valid [NCH];
    logic          ld_ready [NCH];
    logic          par_err  [NCH];
    logic [AW-1:0] mem_addr [NCH];
    logic [AW-1:0] ld_addr  [NCH];
    logic [DW-1:0] mem_wdata[NCH];
    logic [DW-1:0] mem_rdata[NCH];
    logic [DW-1:0] ld_data  [NCH];

    always #5 clk = ~clk;

    cpu_mem_responder #(.WORD_W(DW), .ADDR_W(AW), .RD_WAIT(RDW0), .WR_WAIT(WRW0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .mem_addr(mem_addr[0]), .mem_rd(mem_rd[0]), .mem_wr(mem_wr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
        .mem_ack(mem_ack[0]), .mem_err(mem_err[0]),
        .ld_valid(ld_valid[0]), .ld_ready(ld_ready[0]),
        .ld_addr(ld_addr[0]), .ld_data(ld_data[0]), .par_err(par_err[0])
    );

    cpu_mem_responder #(.WORD_W(DW), .ADDR_W(AW), .RD_WAIT(RDW1), .WR_WAIT(WRW1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .mem_addr(mem_addr[1]), .mem_rd(mem_rd[1]), .mem_wr(mem_wr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
        .mem_ack(mem_ack[1]), .mem_err(mem_err[1]),
        .ld_valid(ld_valid[1]), .ld_ready(ld_ready[1]),
        .ld_addr(ld_addr[1]), .ld_data(ld_data[1]), .par_err(par_err[1])
    );

    typedef struct {
        int            ch;
        int            cyc;
        bit            err;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t          sb_q[$];
    logic [DW-1:0] model_mem [NCH][32];
    logic [DW-1:0] hold_rd   [NCH];
    int            cyc    = 0;
    int            n_chk  = 0;
    int            n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rd_wait(input int ch);
        return (ch == 0) ? RDW0 : RDW1;
    endfunction

    function automatic int wr_wait(input int ch);
        return (ch == 0) ? WRW0 : WRW1;
    endfunction

    // Monitor: every acknowledge must match the oldest expected response.
    always @(negedge clk) begin
        exp_t e;
        for (int c = 0; c < NCH; c++) begin
            if (mem_err[c] === 1'b1 && mem_ack[c] !== 1'b1)
                check("err_without_ack", {31'b0, mem_ack[c]}, 1);
            if (mem_ack[c] === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("ack_with_nothing_expected", sb_q.size(), 1);
                end else begin
                    e = sb_q.pop_front();
                    check("ack_channel", c, e.ch);
                    check("ack_cycle", cyc, e.cyc);
                    check("ack_err", {31'b0, mem_err[c]}, {31'b0, e.err});
                    check("rdata", {24'b0, mem_rdata[c]}, {24'b0, e.rdata});
                end
            end
        end
    end

    // CPU access: kind 0 = read, 1 = write, 2 = both strobes (protocol error).
    // Called at a negedge with the DUT idle; returns at a negedge in IDLE.
    task automatic cpu_op(input int ch, input int kind, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
        exp_t e;
        int   w;
        bit   got;
        w = (kind == 0) ? rd_wait(ch) : (kind == 1) ? wr_wait(ch) : 0;
        e.ch  = ch;
        e.err = (kind == 2);
        e.cyc = cyc + 1 + w;
        if (kind == 0) hold_rd[ch] = model_mem[ch][a];
        e.rdata = hold_rd[ch];
        if (kind == 1) model_mem[ch][a] = d;
        sb_q.push_back(e);
        mem_addr[ch]  = a;
        mem_wdata[ch] = d;
        mem_rd[ch]    = (kind != 1);
        mem_wr[ch]    = (kind != 0);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = (mem_ack[ch] === 1'b1);
        end
        mem_rd[ch] = 1'b0;
        mem_wr[ch] = 1'b0;
        if (!got) begin
            check("ack_timeout", {31'b0, got}, 1);
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    // Loader write; reports how many cycles it waited before acceptance.
    task automatic ld_write(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            output int stall);
        bit ok;
        ok    = 1'b0;
        stall = 0;
        ld_valid[ch] = 1'b1;
        ld_addr[ch]  = a;
        ld_data[ch]  = d;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            ok = (ld_ready[ch] === 1'b1);
            @(negedge clk);
            if (!ok) stall++;
        end
        ld_valid[ch] = 1'b0;
        if (ok) model_mem[ch][a] = d;
        else check("ld_timeout", {31'b0, ok}, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int c = 0; c < NCH; c++) begin
            check({tag, "_ack"},      {31'b0, mem_ack[c]}, 0);
            check({tag, "_err"},      {31'b0, mem_err[c]}, 0);
            check({tag, "_rdata"},    {24'b0, mem_rdata[c]}, 0);
            check({tag, "_ld_ready"}, {31'b0, ld_ready[c]}, 0);
            check({tag, "_par_err"},  {31'b0, par_err[c]}, 0);
        end
    endtask

    initial begin
        int st;
        for (int c = 0; c < NCH; c++) begin
            mem_rd[c] = 0; mem_wr[c] = 0; ld_valid[c] = 0;
            mem_addr[c] = '0; ld_addr[c] = '0; mem_wdata[c] = '0; ld_data[c] = '0;
            hold_rd[c] = '0;
        end
        repeat (3) @(negedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int ch = 0; ch < NCH; ch++) begin
            // Preload every word so all later reads have a known value.
            for (int a = 0; a < 32; a++) begin
                ld_write(ch, AW'(a), DW'($urandom), st);
                check("ld_idle_no_stall", st, 0);
            end
            ld_write(ch, 5'd3, 8'hA5, st);
            ld_write(ch, 5'd31, 8'h1F, st);
            cpu_op(ch, 0, 5'd3, 8'h00);
            cpu_op(ch, 0, 5'd31, 8'h00);
            cpu_op(ch, 1, 5'd7, 8'h3C);
            cpu_op(ch, 0, 5'd7, 8'h00);
            cpu_op(ch, 2, 5'd7, 8'hFF);
            cpu_op(ch, 0, 5'd7, 8'h00);
            cpu_op(ch, 0, 5'd31, 8'h00);
            cpu_op(ch, 2, 5'd31, 8'h00);   // error must leave last read data in place
            // CPU read and loader word in the same idle cycle: CPU wins.
            fork
                cpu_op(ch, 0, 5'd9, 8'h00);
                begin
                    int s;
                    ld_write(ch, 5'd9, 8'hC3, s);
                    check("ld_stall_cycles", s, rd_wait(ch) + 2);
                end
            join
            cpu_op(ch, 0, 5'd9, 8'h00);
            // Randomized mix of reads, writes, errors and loader words.
            for (int i = 0; i < 60; i++) begin
                int k;
                if ($urandom_range(0, 3) == 0)
                    ld_write(ch, AW'($urandom_range(0, 31)), DW'($urandom), st);
                k = $urandom_range(0, 9);
                cpu_op(ch, (k < 5) ? 0 : (k < 9) ? 1 : 2,
                       AW'($urandom_range(0, 31)), DW'($urandom));
            end
        end

        // Reset during the wait states of a write must not commit it.
        ld_write(0, 5'd5, 8'h11, st);
        mem_addr[0]  = 5'd5;
        mem_wdata[0] = 8'h77;
        mem_wr[0]    = 1'b1;
        @(negedge clk);
        rst_n     = 1'b0;
        mem_wr[0] = 1'b0;
        #1 check_reset_outputs("midreset");
        hold_rd[0] = '0;
        hold_rd[1] = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cpu_op(0, 0, 5'd5, 8'h00);
        cpu_op(1, 0, 5'd3, 8'h00);

`ifdef CPU_MEM_PARITY_EN
        ld_write(0, 5'd2, 8'h5A, st);
        check("par_before_flip", {31'b0, par_err[0]}, 0);
        u_dut0.mem[2] = u_dut0.mem[2] ^ 8'h01;
        model_mem[0][2] = 8'h5B;
        cpu_op(0, 0, 5'd2, 8'h00);
        check("par_after_flip", {31'b0, par_err[0]}, 1);
        cpu_op(0, 0, 5'd3, 8'h00);
        check("par_sticky", {31'b0, par_err[0]}, 1);
        rst_n = 1'b0;
        #1 check("par_cleared_by_reset", {31'b0, par_err[0]}, 0);
        hold_rd[0] = '0;
        hold_rd[1] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`else
        check("par_err_tied_low_0", {31'b0, par_err[0]}, 0);
        check("par_err_tied_low_1", {31'b0, par_err[1]}, 0);
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cpu_mem_responder.md
# cpu_mem_responder

- 32×8 memory target for the accumulator CPU.
- Responds to the controller's read/write strobes with a configurable number of wait states and a one-cycle acknowledge.
- Also accepts a handshake-driven program-load port, used to preload instructions before the CPU leaves reset.
- Sits between the CPU controller/datapath and program storage. It is the responding end of the controller's INST_FETCH/OP_FETCH/STORE memory accesses.

## Interface
Parameters:
- WORD_W, 8: data word width (opcode in bits [WORD_W-1:WORD_W-3], address in bits [4:0]).
- ADDR_W, 5: address width; depth = 2**ADDR_W.
- RD_WAIT, 1: wait cycles inserted before a read acknowledge (0–7).
- WR_WAIT, 1: wait cycles inserted before a write acknowledge (0–7).

Ports (clk and rst_n follow the team's naming; one clock; reset is asynchronous and active-low):
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_addr  in  ADDR_W  access address, sampled on acceptance.
- mem_rd  in  1  read request, held by the CPU until mem_ack.
- mem_wr  in  1  write request, held by the CPU until mem_ack.
- mem_wdata  in  WORD_W  write data, sampled on acceptance.
- mem_rdata  out  WORD_W  registered read data.
- mem_ack  out  1  one-cycle completion pulse.
- mem_err  out  1  one-cycle pulse with mem_ack on a protocol error.
- ld_valid  in  1  loader word valid.
- ld_ready  out  1  loader word accepted when ld_valid && ld_ready.
- ld_addr  in  ADDR_W  loader address.
- ld_data  in  WORD_W  loader data.
- par_err  out  1  sticky parity error (MEM_PARITY_EN only; tied 0 otherwise).

## Operation
FSM states and transitions:
- IDLE: sample the request signals at each edge.
  - mem_rd only → RD_W (or RESP if RD_WAIT=0).
  - mem_wr only → WR_W (or RESP if WR_WAIT=0).
  - Both high → ERR.
  - Neither high → stay in IDLE.
- In all accepting cases, latch mem_addr/mem_wdata and load the wait counter with RD_WAIT/WR_WAIT.
- RD_W/WR_W: decrement the counter each cycle; go to RESP when the counter reaches 1.
- RESP: mem_ack=1 for exactly one cycle, then → IDLE.
  - Read: mem_rdata is loaded from mem[latched addr] at the edge entering RESP.
  - Write: mem[latched addr] is written at the same edge.
- ERR: mem_ack=1 and mem_err=1 for one cycle, then → IDLE. No memory change; mem_rdata holds its value.

Request and data rules:
- The CPU drops its request in the cycle mem_ack is high. A request still high in the next IDLE cycle is a new access.
- mem_rdata holds its value until the next read completes.
- Request inputs are ignored outside IDLE; changes mid-access have no effect.

Loader port:
- ld_ready = rst_n && state==IDLE && !mem_rd && !mem_wr. The CPU has priority.
- On ld_valid && ld_ready, mem[ld_addr] ← ld_data at that edge.
- No acknowledge is issued to the CPU for loader writes.

Reset and address rules:
- Reset values: mem_rdata=0, mem_ack=0, mem_err=0, ld_ready=0, par_err=0, state=IDLE, counter=0.
- Memory contents are not reset.
- Reset asserted mid-access aborts the access; a write not yet at its RESP edge is not committed.
- Address wraps naturally modulo 2**ADDR_W. There is no out-of-range case.

## Timing
- A request sampled at edge k produces mem_ack high in the cycle after edge k+W, where W = RD_WAIT or WR_WAIT. Latency is W+1 cycles.
- Back-to-back accesses: minimum spacing is W+2 edges (one IDLE cycle between accesses).
- Loader write: single-cycle throughput while idle. Zero latency to memory, so a CPU read one IDLE cycle later sees the data.
- Loader and CPU requests in the same IDLE cycle: the CPU request is accepted and the loader stalls (ld_ready=0).
- Outputs mem_ack, mem_err and mem_rdata are registered. ld_ready is combinational from state and the request inputs.

## Configuration
Macro: CPU_MEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit, computed on CPU and loader writes.
  - On a read, parity of the stored word is checked at the RESP edge; a mismatch sets par_err.
  - par_err is sticky until rst_n.
  - mem_rdata is still returned.
- Undefined: no parity storage, and par_err is tied to 0.

## Test plan
- Loader preload: write 0xA5 to address 3 and 0x1F to address 31 via the loader, with RD_WAIT=1. A CPU read of address 3 gives mem_ack in the 2nd cycle after acceptance with mem_rdata=0xA5. A read of address 31 gives 0x1F.
- Write then read, WR_WAIT=2, RD_WAIT=0: write 0x3C to address 7 gives ack 3 cycles after acceptance. The following read of address 7 gives ack 1 cycle after acceptance with 0x3C.
- mem_rd and mem_wr both high in IDLE: next cycle mem_ack=1 and mem_err=1; memory and mem_rdata are unchanged.
- Loader ld_valid in the same cycle as a CPU read: ld_ready=0 and the read completes. The loader word is accepted in the first IDLE cycle with no CPU request.
- Reset asserted during WR_W (write of 0x77 to address 5, previous content 0x11): outputs return to reset values, and a read of address 5 after reset returns 0x11.
- With CPU_MEM_PARITY_EN defined: force a stored bit flip at address 2, then read it. par_err rises at the RESP edge and stays high until rst_n.
